mouse_c1351: RTL and testbench

Emulates a Commodore 1351 proportional mouse on one C64 control port. It consumes the mouse reports that the HID receiver decodes from the IO MCU (`mouse_btns`, `mouse_x`, `mouse_y`, `mouse_strobe`) and produces two outputs:
- the SID POTX/POTY readings;
- the active-low joystick-line button bits for the CIA port mux.

Motion is accumulated and released at a bounded rate per SID pot-sampling period, so the 6-bit position the C64 driver sees never aliases.

---
 rtl/c64_pkg.sv | 38 +++
 rtl/c1351_axis.sv | 61 ++++++
 rtl/mouse_c1351.sv | 117 +++++++++++
 tb/tb_mouse_c1351.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/c64_pkg.sv
// Shared C64 peripheral constants and the 1351 helper types/functions.
package c64_pkg;

  localparam int unsigned C1351_ACC_W = 10;
  localparam int unsigned C1351_POS_W = 6;
  localparam int unsigned C1351_DIV_W = 10;
  localparam int unsigned C1351_SUM_W = 12;
  localparam int unsigned JOY_W       = 5;

  localparam logic [7:0] C1351_POT_BASE = 8'd64;
  localparam logic [7:0] C1351_POT_IDLE = 8'hFF;

  localparam int unsigned JOY_UP    = 0;
  localparam int unsigned JOY_DOWN  = 1;
  localparam int unsigned JOY_LEFT  = 2;
  localparam int unsigned JOY_RIGHT = 3;
  localparam int unsigned JOY_FIRE  = 4;

  // Button payload as delivered by the HID receiver: bit1 right, bit0 left.
  typedef struct packed {
    logic right;
    logic left;
  } c1351_btn_t;

  // Clamp a widened sum back into the signed accumulator range.
  function automatic logic signed [C1351_ACC_W-1:0] c1351_sat(
    input logic signed [C1351_SUM_W-1:0] v
  );
    if (v > 12'sd511) begin
      return 10'sd511;
    end else if (v < -12'sd512) begin
      return -10'sd512;
    end else begin
      return $signed(v[C1351_ACC_W-1:0]);
    end
  endfunction

endpackage

// File: rtl/c1351_axis.sv
// One 1351 axis: saturating motion accumulator, per-period step clamp and
// the 6-bit wrapping position the C64 driver observes.
module c1351_axis
  import c64_pkg::*;
#(
  parameter int unsigned MAX_STEP = 31
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr,
  input  logic                   add_en,
  input  logic [C1351_ACC_W-1:0] delta,
  input  logic                   step_en,
  output logic [C1351_POS_W-1:0] pos
);

  localparam logic signed [C1351_ACC_W-1:0] STEP_HI = 10'(MAX_STEP);
  localparam logic signed [C1351_ACC_W-1:0] STEP_LO = -STEP_HI;

  logic signed [C1351_ACC_W-1:0] acc_q, acc_d;
  logic signed [C1351_ACC_W-1:0] step_c;
  logic signed [C1351_SUM_W-1:0] sum_c;
  logic        [C1351_POS_W-1:0] pos_q, pos_d;

  // Step is taken from the pre-update accumulator; a coincident report is
  // folded into the same sum so nothing is lost or counted twice.
  always_comb begin
    step_c = '0;
    if (step_en) begin
      if (acc_q > STEP_HI) begin
        step_c = STEP_HI;
      end else if (acc_q < STEP_LO) begin
        step_c = STEP_LO;
      end else begin
        step_c = acc_q;
      end
    end

    sum_c = $signed({{2{acc_q[C1351_ACC_W-1]}}, acc_q})
          - $signed({{2{step_c[C1351_ACC_W-1]}}, step_c});
    if (add_en) begin
      sum_c = sum_c + $signed({{2{delta[C1351_ACC_W-1]}}, delta});
    end

    acc_d = clr ? '0 : c1351_sat(sum_c);
    pos_d = pos_q + step_c[C1351_POS_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      pos_q <= '0;
    end else begin
      acc_q <= acc_d;
      pos_q <= pos_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/mouse_c1351.sv
// Commodore 1351 proportional mouse emulation for one C64 control port:
// HID reports in, SID POTX/POTY values and active-low button lines out.
module mouse_c1351
  import c64_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 512,
  parameter int unsigned MAX_STEP   = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             phi2_en,
  input  logic             enable,
  input  logic             mouse_strobe,
  input  logic [1:0]       mouse_btns,
  input  logic [7:0]       mouse_x,
  input  logic [7:0]       mouse_y,
  output logic [7:0]       pot_x,
  output logic [7:0]       pot_y,
  output logic [JOY_W-1:0] joy_n,
  output logic             tick
);

  localparam logic [C1351_DIV_W-1:0] DIV_LAST = 10'(SAMPLE_DIV - 1);

  logic [C1351_DIV_W-1:0] div_q, div_d;
  logic                   tick_q, tick_d;
  c1351_btn_t             btn_q, btn_d;
  logic [7:0]             pot_x_q, pot_x_d;
  logic [7:0]             pot_y_q, pot_y_d;
  logic [JOY_W-1:0]       joy_q, joy_d;

  logic                   wrap_c;
  logic                   step_en_c;
  logic                   add_en_c;
  logic [C1351_ACC_W-1:0] dx_c, dy_c;
  logic [C1351_POS_W-1:0] pos_x, pos_y;

  // Divider freezes while the port is not in 1351 mode so the period phase
  // survives a mode switch.
  always_comb begin
    div_d  = div_q;
    wrap_c = enable && phi2_en && (div_q == DIV_LAST);
    if (enable && phi2_en) begin
      div_d = wrap_c ? '0 : div_q + 10'd1;
    end
    tick_d = wrap_c;
  end

  // The cycle flagged by tick is the cycle the positions step.
  always_comb begin
    step_en_c = tick_q && enable;
    add_en_c  = enable && mouse_strobe;
    dx_c      = {{2{mouse_x[7]}}, mouse_x};
    dy_c      = 10'd0 - {{2{mouse_y[7]}}, mouse_y};
  end

  always_comb begin
    btn_d = btn_q;
    if (enable && mouse_strobe) begin
      btn_d = c1351_btn_t'(mouse_btns);
    end

    pot_x_d = C1351_POT_IDLE;
    pot_y_d = C1351_POT_IDLE;
    joy_d   = 5'h1F;
    if (enable) begin
      pot_x_d         = C1351_POT_BASE + {1'b0, pos_x, 1'b0};
      pot_y_d         = C1351_POT_BASE + {1'b0, pos_y, 1'b0};
      joy_d[JOY_FIRE] = ~btn_q.left;
      joy_d[JOY_UP]   = ~btn_q.right;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      btn_q   <= '0;
      pot_x_q <= C1351_POT_BASE;
      pot_y_q <= C1351_POT_BASE;
      joy_q   <= 5'h1F;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      btn_q   <= btn_d;
      pot_x_q <= pot_x_d;
      pot_y_q <= pot_y_d;
      joy_q   <= joy_d;
    end
  end

  c1351_axis #(.MAX_STEP(MAX_STEP)) u_axis_x (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!enable),
    .add_en  (add_en_c),
    .delta   (dx_c),
    .step_en (step_en_c),
    .pos     (pos_x)
  );

  c1351_axis #(.MAX_STEP(MAX_STEP)) u_axis_y (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!enable),
    .add_en  (add_en_c),
    .delta   (dy_c),
    .step_en (step_en_c),
    .pos     (pos_y)
  );

  assign pot_x = pot_x_q;
  assign pot_y = pot_y_q;
  assign joy_n = joy_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_mouse_c1351.sv
// Bench for mouse_c1351: directed vector table, hand-built corner sequences
// and random traffic against an integer reference model of the mouse.
module tb_mouse_c1351;

  localparam int SAMPLE_DIV = 512;
  localparam int MAX_STEP   = 31;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       phi2_en, enable, mouse_strobe;
  logic [1:0] mouse_btns;
  logic [7:0] mouse_x, mouse_y;
  logic [7:0] pot_x, pot_y;
  logic [4:0] joy_n;
  logic       tick;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: plain integers, position kept modulo 64.
  int  m_ax, m_ay, m_px, m_py, m_btn, m_cnt;
  bit  m_pend;

  typedef struct {
    int         x;
    int         y;
    int         b;
    int         periods;
    logic [7:0] ex;
    logic [7:0] ey;
    logic [4:0] ej;
  } vec_t;
  vec_t vecs[6];

  mouse_c1351 #(.SAMPLE_DIV(SAMPLE_DIV), .MAX_STEP(MAX_STEP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .phi2_en      (phi2_en),
    .enable       (enable),
    .mouse_strobe (mouse_strobe),
    .mouse_btns   (mouse_btns),
    .mouse_x      (mouse_x),
    .mouse_y      (mouse_y),
    .pot_x        (pot_x),
    .pot_y        (pot_y),
    .joy_n        (joy_n),
    .tick         (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  function automatic int clampstep(input int v);
    if (v > MAX_STEP) return MAX_STEP;
    if (v < -MAX_STEP) return -MAX_STEP;
    return v;
  endfunction

  function automatic int joy_of(input int b);
    return ((b & 1) != 0 ? 0 : 16) | 14 | ((b & 2) != 0 ? 0 : 1);
  endfunction

  task automatic model_reset();
    m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_btn = 0; m_cnt = 0; m_pend = 0;
  endtask

  // One clock of stimulus, model update, and output comparison.
  task automatic cyc(input bit en, input bit phi, input bit stb,
                     input int b, input int x, input int y);
    int sx, sy, opx, opy, ob;
    bit e_tick;
    @(negedge clk);
    enable = en; phi2_en = phi; mouse_strobe = stb;
    mouse_btns = 2'(b); mouse_x = 8'(x); mouse_y = 8'(y);
    opx = m_px; opy = m_py; ob = m_btn;
    sx = (m_pend && en) ? clampstep(m_ax) : 0;
    sy = (m_pend && en) ? clampstep(m_ay) : 0;
    if (!en) begin
      m_ax = 0; m_ay = 0;
    end else begin
      m_ax = sat(m_ax + (stb ? x : 0) - sx);
      m_ay = sat(m_ay + (stb ? -y : 0) - sy);
    end
    m_px = (m_px + sx + 64) % 64;
    m_py = (m_py + sy + 64) % 64;
    if (en && stb) m_btn = b;
    e_tick = en && phi && (m_cnt == SAMPLE_DIV - 1);
    if (en && phi) m_cnt = (m_cnt + 1) % SAMPLE_DIV;
    m_pend = e_tick;
    @(posedge clk);
    #1;
    chk("tick", int'(tick), int'(e_tick));
    chk("pot_x", int'(pot_x), en ? 64 + 2 * opx : 255);
    chk("pot_y", int'(pot_y), en ? 64 + 2 * opy : 255);
    chk("joy_n", int'(joy_n), en ? joy_of(ob) : 31);
  endtask

  task automatic idle(input int n, input bit phi);
    for (int i = 0; i < n; i++) cyc(1'b1, phi, 1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    enable = 1'b0; phi2_en = 1'b0; mouse_strobe = 1'b0;
    mouse_btns = '0; mouse_x = '0; mouse_y = '0;
    #2;
    chk("rst_pot_x", int'(pot_x), 'h40);
    chk("rst_pot_y", int'(pot_y), 'h40);
    chk("rst_joy_n", int'(joy_n), 'h1F);
    chk("rst_tick", int'(tick), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit en;
    reset_n = 1'b0;
    enable = 1'b0; phi2_en = 1'b0; mouse_strobe = 1'b0;
    mouse_btns = '0; mouse_x = '0; mouse_y = '0;
    model_reset();

    vecs[0] = '{x:   10, y:    0, b: 0, periods: 1, ex: 8'h54, ey: 8'h40, ej: 5'h1F};
    vecs[1] = '{x:  100, y:    0, b: 0, periods: 4, ex: 8'h88, ey: 8'h40, ej: 5'h1F};
    vecs[2] = '{x:    0, y:    5, b: 0, periods: 1, ex: 8'h40, ey: 8'hB6, ej: 5'h1F};
    vecs[3] = '{x:    0, y:    0, b: 3, periods: 1, ex: 8'h40, ey: 8'h40, ej: 5'h0E};
    vecs[4] = '{x:   -3, y: -128, b: 1, periods: 2, ex: 8'hBA, ey: 8'hBC, ej: 5'h0F};
    vecs[5] = '{x: -128, y:    0, b: 2, periods: 4, ex: 8'h48, ey: 8'h40, ej: 5'h1E};

    // Directed table: one report, N full periods, then settle.
    foreach (vecs[k]) begin
      do_reset();
      cyc(1'b1, 1'b0, 1'b1, vecs[k].b, vecs[k].x, vecs[k].y);
      idle(vecs[k].periods * SAMPLE_DIV, 1'b1);
      idle(3, 1'b0);
      chk("tbl_pot_x", int'(pot_x), int'(vecs[k].ex));
      chk("tbl_pot_y", int'(pot_y), int'(vecs[k].ey));
      chk("tbl_joy_n", int'(joy_n), int'(vecs[k].ej));
    end

    // Button latency: strobe to joy_n takes two cycles.
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 3, 0, 0);
    chk("btn_lat1", int'(joy_n), 'h1F);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0);
    chk("btn_lat2", int'(joy_n), 'h0E);

    // Report landing exactly on the step cycle.
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 0, 40, 0);
    for (int i = 0; i < 600 && !m_pend; i++) cyc(1'b1, 1'b1, 1'b0, 0, 0, 0);
    if (!m_pend) begin
      n_vec++; n_bad++;
      $display("FAIL wrap_timeout: got no step cycle expected one within 600 cycles");
    end
    cyc(1'b1, 1'b1, 1'b1, 0, 3, 0);
    idle(3, 1'b0);
    chk("coinc_pos31", int'(pot_x), 'h7E);
    idle(SAMPLE_DIV, 1'b1);
    idle(3, 1'b0);
    chk("coinc_pos43", int'(pot_x), 'h96);

    // Saturation, drain, then enable off/on.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 0, 127, 0);
    idle(3 * SAMPLE_DIV, 1'b1);
    idle(3, 1'b0);
    chk("sat_3per", int'(pot_x), 'h7A);
    idle(14 * SAMPLE_DIV, 1'b1);
    idle(3, 1'b0);
    chk("sat_drain", int'(pot_x), 'hBE);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 3, 50, 50);
    chk("dis_pot_x", int'(pot_x), 'hFF);
    chk("dis_pot_y", int'(pot_y), 'hFF);
    chk("dis_joy_n", int'(joy_n), 'h1F);
    idle(3, 1'b0);
    chk("reen_pot_x", int'(pot_x), 'hBE);
    chk("reen_joy_n", int'(joy_n), 'h1F);
    idle(SAMPLE_DIV, 1'b1);
    idle(3, 1'b0);
    chk("reen_hold", int'(pot_x), 'hBE);

    // phi2_en held low: no steps, but the report stays pending.
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 0, 20, 0);
    idle(1500, 1'b0);
    chk("nophi_pot", int'(pot_x), 'h40);
    idle(SAMPLE_DIV, 1'b1);
    idle(3, 1'b0);
    chk("nophi_step", int'(pot_x), 'h68);

    // Asynchronous reset mid-period discards pending motion.
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 1, 50, -20);
    idle(300, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pot_x", int'(pot_x), 'h40);
    chk("arst_joy_n", int'(joy_n), 'h1F);
    enable = 1'b0; phi2_en = 1'b0; mouse_strobe = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    idle(SAMPLE_DIV, 1'b1);
    idle(3, 1'b0);
    chk("arst_disc_x", int'(pot_x), 'h40);
    chk("arst_disc_y", int'(pot_y), 'h40);

    // Random traffic against the model.
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(499) == 0) en = !en;
      cyc(en, 1'($urandom_range(1)), ($urandom_range(7) == 0),
          int'($urandom_range(3)), int'($urandom_range(255)) - 128,
          int'($urandom_range(255)) - 128);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
